// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative RV32M divider (DIV, DIVU, REM, REMU). One radix-2 restoring step
//   per clock on a 33-bit partial remainder, 32 steps per operation. Latency is
//   fixed: start accepted at edge E0, done pulses in the cycle after edge E32,
//   back in IDLE at E33. Divide-by-zero and signed overflow are detected at
//   acceptance and substituted at completion, so they keep the full latency.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   start     in   request a division (accepted only in IDLE without kill)
//   op        in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   rs1 operand, sampled on accept
//   divisor   in   rs2 operand, sampled on accept
//   kill      in   synchronous abort; forces IDLE on the next edge
//   busy      out  1 in CALC and DONE
//   done      out  one-cycle pulse, result valid in that cycle
//   result    out  registered quotient or remainder, held until next done
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  count;
    logic [32:0] rem;           // partial remainder
    logic [31:0] quo;           // dividend bits shifting out / quotient shifting in
    logic [31:0] dvs;           // magnitude of divisor
    logic [31:0] dividend_orig; // unmodified rs1, needed for REM by zero
    logic        is_rem;
    logic        neg_quo;
    logic        neg_rem;
    logic        div_zero;
    logic        overflow;

    // ---------------------------------------------------------------------
    // Acceptance-side decode of the incoming operands
    // ---------------------------------------------------------------------
    logic        op_signed;
    logic        dividend_neg;
    logic        divisor_neg;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic        accept;
    logic        last_step;

    assign op_signed    = ~op[0];
    assign dividend_neg = op_signed & dividend[31];
    assign divisor_neg  = op_signed & divisor[31];
    assign dividend_abs = dividend_neg ? (32'd0 - dividend) : dividend;
    assign divisor_abs  = divisor_neg  ? (32'd0 - divisor)  : divisor;

    assign accept    = (state == IDLE) & start & ~kill;
    assign last_step = (state == CALC) & (count == 5'd31) & ~kill;

    // ---------------------------------------------------------------------
    // One restoring step. The remainder stays below the divisor, so the
    // shifted value is below 2*divisor and bit 32 of the trial difference is
    // set only when the subtraction borrows.
    // ---------------------------------------------------------------------
    logic [32:0] rem_shift;
    logic [32:0] rem_trial;
    logic        no_borrow;
    logic [32:0] rem_step;
    logic [31:0] quo_step;

    assign rem_shift = {rem[31:0], quo[31]};
    assign rem_trial = rem_shift - {1'b0, dvs};
    assign no_borrow = ~rem_trial[32];
    assign rem_step  = no_borrow ? rem_trial : rem_shift;
    assign quo_step  = {quo[30:0], no_borrow};

    // ---------------------------------------------------------------------
    // Final value: sign fixup of the last step, then special-case override
    // ---------------------------------------------------------------------
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_value;

    assign quo_fix = neg_quo ? (32'd0 - quo_step) : quo_step;
    assign rem_fix = neg_rem ? (32'd0 - rem_step[31:0]) : rem_step[31:0];

    always_comb begin
        if (div_zero)
            final_value = is_rem ? dividend_orig : 32'hFFFF_FFFF;
        else if (overflow)
            final_value = is_rem ? 32'd0 : 32'h8000_0000;
        else
            final_value = is_rem ? rem_fix : quo_fix;
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // kill wins over start and over the DONE transition
        if (kill)
            state_next = IDLE;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= 5'd0;
            rem           <= 33'd0;
            quo           <= 32'd0;
            dvs           <= 32'd0;
            dividend_orig <= 32'd0;
            is_rem        <= 1'b0;
            neg_quo       <= 1'b0;
            neg_rem       <= 1'b0;
            div_zero      <= 1'b0;
            overflow      <= 1'b0;
        end else if (kill) begin
            count <= 5'd0;
        end else if (accept) begin
            count         <= 5'd0;
            rem           <= 33'd0;
            quo           <= dividend_abs;
            dvs           <= divisor_abs;
            dividend_orig <= dividend;
            is_rem        <= op[1];
            neg_quo       <= dividend_neg ^ divisor_neg;
            neg_rem       <= dividend_neg;
            div_zero      <= (divisor == 32'd0);
            overflow      <= op_signed & (dividend == 32'h8000_0000)
                                       & (divisor == 32'hFFFF_FFFF);
        end else if (state == CALC) begin
            // count wraps 31 -> 0 on the last step, leaving it cleared in DONE
            count <= count + 5'd1;
            rem   <= rem_step;
            quo   <= quo_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            result <= 32'd0;
        else if (last_step)
            result <= final_value;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; latency fixed at 32 iteration cycles.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled on the rising edge of clk.
REQ-005 op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of RV32M 1xx).
REQ-006 dividend  input  32  rs1 operand; sampled only on an accepted start.
REQ-007 divisor  input  32  rs2 operand; sampled only on an accepted start.
REQ-008 kill  input  1  synchronous abort, e.g. on pipeline flush.
REQ-009 busy  output  1  high when state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  32  quotient or remainder, registered.

Function
REQ-012 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-013 Start acceptance: in IDLE with start=1 and kill=0, the block SHALL latch op and the operands, then enter CALC with iteration counter=0.
REQ-014 start while busy=1 SHALL be ignored; no re-latch and no restart.
REQ-015 Signed ops (DIV, REM) SHALL latch absolute values of both operands and record sign flags.
REQ-016 Unsigned ops SHALL latch the operands unmodified.
REQ-017 CALC SHALL perform one radix-2 restoring step per cycle on a 33-bit partial remainder.
REQ-018 Each CALC step: shift {rem,quo} left by 1; trial-subtract the divisor; if no borrow, keep the difference and set the quotient LSB to 1.
REQ-019 After the 32nd CALC step (counter==31), the block SHALL enter DONE and register the final result on that same edge.
REQ-020 Latency: start accepted at edge E0 -> done=1 in the cycle following edge E32 -> IDLE at E33.
REQ-021 Latency is 32 cycles from acceptance to done, for every operand combination including the special cases.
REQ-022 Sign fixup for DIV: quotient SHALL be negated when sign(dividend) XOR sign(divisor) is 1.
REQ-023 Sign fixup for REM: remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero SHALL give: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = original dividend.
REQ-025 Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF) SHALL give: DIV result 0x80000000; REM result 0.
REQ-026 The special cases SHALL be detected at acceptance, override the iterated value in DONE, and keep full latency.
REQ-027 DONE SHALL last exactly one cycle.
REQ-028 From DONE the block SHALL return to IDLE, even if start=1 in DONE; that start is not accepted.
REQ-029 result SHALL hold its value until the next DONE.
REQ-030 kill=1 in any state SHALL force IDLE on the next edge, with done=0 and result unchanged.
REQ-031 kill SHALL take priority over start and over the DONE transition.
REQ-032 busy SHALL be a registered-state decode: 1 in CALC and DONE, 0 in IDLE.

Reset
REQ-033 On reset assertion, the block SHALL immediately enter IDLE with counter=0, busy=0, done=0 and result=0.
REQ-034 Reset asserted mid-CALC SHALL abandon the operation with no done pulse; the first start after deassertion SHALL be accepted normally.

Verification
REQ-035 DIV 100 / 7 -> done exactly 32 cycles after accept, result=14; REM 100 % 7 -> result=2.
REQ-036 DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 % 2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-037 DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 % 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; all with 32-cycle latency.
REQ-038 start held high for 40 cycles with operands changing -> exactly one accept; result uses E0 operands; second accept at E34.
REQ-039 kill at iteration 10 -> IDLE next cycle, no done, result unchanged; a new start the following cycle completes correctly.
REQ-040 reset pulse during CALC -> busy=0, done=0, result=0 immediately; no spurious done; random signed/unsigned operand sweep matches a reference model.
